scanline_buffer: RTL and testbench

SCANLINE_BUFFER -- requirements
Module: scanline_buffer

---
 rtl/scanline_buffer.sv | 211 +++++++++++++++++++++
 tb/tb_scanline_buffer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scanline_buffer.sv
// rtl/scanline_buffer.sv - double-banked VGA scanline buffer with line-fill request FSM
// Optional macro PALETTE_EN: adds a 16 x 24-bit palette ROM stage and Red/Green/Blue outputs.
module scanline_buffer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic       Clk,
    input  logic       Reset_N,
    input  logic       fifo_we,
    input  logic [9:0] fifo_address,
    input  logic [3:0] data_in,
    input  logic       pixel_en,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       fill_req,
    output logic [9:0] fill_line,
`ifdef PALETTE_EN
    output logic [7:0] Red,
    output logic [7:0] Green,
    output logic [7:0] Blue,
`else
    output logic [3:0] colorIndex_out,
`endif
    output logic       pixel_valid,
    output logic       underrun,
    input  logic       underrun_clr
);

    localparam int AW = $clog2(H_ACTIVE);
    localparam int CW = $clog2(H_ACTIVE + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FILL = 2'd2,
        S_FULL = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            rd_bank_q, rd_bank_d;
    logic [CW-1:0]   count_q, count_d;
    logic [9:0]      fill_line_q, fill_line_d;
    logic            underrun_q, underrun_d;
    logic            disp_full_q, disp_full_d;
    logic [3:0]      color_q, color_d;

    // Bank contents carry no reset; pixel_valid gates their use.
    logic [3:0]      bank_mem [2][H_ACTIVE];

    logic            swap;
    logic            good_swap;
    logic            wr_full;
    logic            addr_ok;
    logic            wr_en;
    logic [10:0]     line_plus2;
    logic [9:0]      next_line;
    logic [3:0]      rd_pix;

    assign swap      = pixel_en && (DrawX == 10'(H_ACTIVE - 1)) && (DrawY < 10'(V_ACTIVE));
    assign good_swap = swap && (state_q == S_FULL);
    assign wr_full   = (count_q == CW'(H_ACTIVE));
    assign addr_ok   = (fifo_address < 10'(H_ACTIVE));
    assign wr_en     = fifo_we && addr_ok && !wr_full;

    // The line after the one about to be shown is the next to fetch.
    assign line_plus2 = {1'b0, DrawY} + 11'd2;
    assign next_line  = (line_plus2 >= 11'(V_ACTIVE)) ? 10'(line_plus2 - 11'(V_ACTIVE))
                                                      : line_plus2[9:0];

    assign rd_pix = bank_mem[rd_bank_q][DrawX[AW-1:0]];

    // Writes always target the bank opposite the one being displayed this cycle.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            bank_mem[~rd_bank_q][fifo_address[AW-1:0]] <= data_in;
        end
    end

    always_comb begin
        rd_bank_d   = rd_bank_q;
        count_d     = count_q;
        fill_line_d = fill_line_q;
        underrun_d  = underrun_q;
        disp_full_d = disp_full_q;

        if (wr_en && !swap) begin
            count_d = count_q + 1'b1;
        end
        if (underrun_clr) begin
            underrun_d = 1'b0;
        end
        if (swap) begin
            count_d = '0;
            if (good_swap) begin
                rd_bank_d   = ~rd_bank_q;
                fill_line_d = next_line;
                disp_full_d = 1'b1;
            end else begin
                underrun_d  = 1'b1;
            end
        end
    end

    always_comb begin
        color_d = 4'd0;
        if (pixel_en && (DrawX < 10'(H_ACTIVE))) begin
            color_d = rd_pix;
        end
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            rd_bank_q   <= 1'b0;
            count_q     <= '0;
            fill_line_q <= 10'd0;
            underrun_q  <= 1'b0;
            disp_full_q <= 1'b0;
            color_q     <= 4'd0;
        end else begin
            rd_bank_q   <= rd_bank_d;
            count_q     <= count_d;
            fill_line_q <= fill_line_d;
            underrun_q  <= underrun_d;
            disp_full_q <= disp_full_d;
            color_q     <= color_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Any swap returns to REQ: a good one asks for the next line, a bad one re-asks.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ:   state_d = swap ? S_REQ : S_FILL;
            S_FILL: begin
                if (swap) begin
                    state_d = S_REQ;
                end else if (wr_full) begin
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (swap) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fill_req = 1'b0;
        if (state_q == S_REQ) begin
            fill_req = 1'b1;
        end
    end

    assign fill_line   = fill_line_q;
    assign pixel_valid = disp_full_q;
    assign underrun    = underrun_q;

`ifdef PALETTE_EN
    function automatic logic [23:0] palette(input logic [3:0] idx);
        logic [23:0] rgb;
        case (idx)
            4'd0:    rgb = 24'h000000;
            4'd1:    rgb = 24'hFFFFFF;
            4'd2:    rgb = 24'h808080;
            4'd3:    rgb = 24'hFF0000;
            4'd4:    rgb = 24'h00FF00;
            4'd5:    rgb = 24'h0000FF;
            4'd6:    rgb = 24'hFFFF00;
            4'd7:    rgb = 24'h00FFFF;
            4'd8:    rgb = 24'hFF00FF;
            4'd9:    rgb = 24'h800000;
            4'd10:   rgb = 24'h008000;
            4'd11:   rgb = 24'h000080;
            4'd12:   rgb = 24'h808000;
            4'd13:   rgb = 24'h008080;
            4'd14:   rgb = 24'h800080;
            default: rgb = 24'hC0C0C0;
        endcase
        return rgb;
    endfunction

    logic [23:0] rgb_q;

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            rgb_q <= 24'h000000;
        end else begin
            rgb_q <= palette(color_q);
        end
    end

    assign Red   = rgb_q[23:16];
    assign Green = rgb_q[15:8];
    assign Blue  = rgb_q[7:0];
`else
    assign colorIndex_out = color_q;
`endif

endmodule

// File: tb/tb_scanline_buffer.sv
// tb/tb_scanline_buffer.sv - directed, table-driven bench for scanline_buffer (default build)
module tb_scanline_buffer;

    logic       Clk = 1'b0;
    logic       Reset_N;
    logic       fifo_we;
    logic [9:0] fifo_address;
    logic [3:0] data_in;
    logic       pixel_en;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       fill_req;
    logic [9:0] fill_line;
    logic [3:0] colorIndex_out;
    logic       pixel_valid;
    logic       underrun;
    logic       underrun_clr;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       pe;
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] exp_c;
        logic       exp_v;
    } vec_t;

    vec_t tbl [9];

    always #5 Clk = ~Clk;

    scanline_buffer #(.H_ACTIVE(640), .V_ACTIVE(480)) dut (
        .Clk            (Clk),
        .Reset_N        (Reset_N),
        .fifo_we        (fifo_we),
        .fifo_address   (fifo_address),
        .data_in        (data_in),
        .pixel_en       (pixel_en),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .fill_req       (fill_req),
        .fill_line      (fill_line),
        .colorIndex_out (colorIndex_out),
        .pixel_valid    (pixel_valid),
        .underrun       (underrun),
        .underrun_clr   (underrun_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        fifo_we      = 1'b0;
        fifo_address = 10'd0;
        data_in      = 4'd0;
        pixel_en     = 1'b0;
        DrawX        = 10'd0;
        DrawY        = 10'd480;
        underrun_clr = 1'b0;
    endtask

    task automatic wait_fill_req(input int max_cyc, input string name);
        int k;
        k = 0;
        while (fill_req !== 1'b1 && k < max_cyc) begin
            step();
            k++;
        end
        check(name, fill_req, 1);
    endtask

    task automatic write_line(input int first, input int last, input bit inverted);
        for (int i = first; i <= last; i++) begin
            fifo_we      = 1'b1;
            fifo_address = 10'(i);
            data_in      = inverted ? 4'(15 - (i % 16)) : 4'(i % 16);
            step();
        end
        fifo_we = 1'b0;
    endtask

    task automatic do_swap(input int y);
        pixel_en = 1'b1;
        DrawX    = 10'd639;
        DrawY    = 10'(y);
        step();
        pixel_en = 1'b0;
        DrawY    = 10'd480;
    endtask

    task automatic clear_underrun();
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
    endtask

    task automatic read_px(input int x, input logic [3:0] exp_c, input string name);
        pixel_en = 1'b1;
        DrawX    = 10'(x);
        DrawY    = 10'd480;
        step();
        pixel_en = 1'b0;
        check(name, colorIndex_out, exp_c);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 10'd5,    10'd0,   4'd5,  1'b1};
        tbl[1] = '{1'b1, 10'd0,    10'd0,   4'd0,  1'b1};
        tbl[2] = '{1'b1, 10'd15,   10'd0,   4'd15, 1'b1};
        tbl[3] = '{1'b1, 10'd16,   10'd0,   4'd0,  1'b1};
        tbl[4] = '{1'b1, 10'd333,  10'd0,   4'd13, 1'b1};
        tbl[5] = '{1'b1, 10'd639,  10'd480, 4'd15, 1'b1};
        tbl[6] = '{1'b1, 10'd640,  10'd0,   4'd0,  1'b1};
        tbl[7] = '{1'b0, 10'd7,    10'd0,   4'd0,  1'b1};
        tbl[8] = '{1'b1, 10'd1023, 10'd0,   4'd0,  1'b1};

        idle_inputs();
        Reset_N = 1'b1;
        #2;
        Reset_N = 1'b0;
        #1;
        check("rst_fill_req", fill_req, 0);
        check("rst_fill_line", fill_line, 0);
        check("rst_color", colorIndex_out, 0);
        check("rst_valid", pixel_valid, 0);
        check("rst_underrun", underrun, 0);
        step();
        step();
        Reset_N = 1'b1;

        wait_fill_req(5, "first_fill_req");
        check("first_fill_line", fill_line, 0);
        step();
        check("first_fill_req_pulse", fill_req, 0);

        // 639 real pixels plus an out-of-range write must not complete the line.
        write_line(0, 638, 1'b0);
        fifo_we = 1'b1; fifo_address = 10'd700; data_in = 4'd9;
        step();
        fifo_we = 1'b0;
        step();
        step();
        do_swap(479);
        check("oob_underrun", underrun, 1);
        check("oob_refill_req", fill_req, 1);
        check("oob_refill_line", fill_line, 0);
        check("oob_valid", pixel_valid, 0);
        clear_underrun();
        check("clr_underrun", underrun, 0);
        check("refill_req_pulse", fill_req, 0);

        write_line(0, 639, 1'b0);
        step();
        step();
        do_swap(479);
        check("swap_underrun", underrun, 0);
        check("swap_fill_req", fill_req, 1);
        check("swap_fill_line", fill_line, 1);
        check("swap_valid", pixel_valid, 1);
        step();
        check("swap_fill_req_pulse", fill_req, 0);

        for (int i = 0; i < 9; i++) begin
            pixel_en = tbl[i].pe;
            DrawX    = tbl[i].x;
            DrawY    = tbl[i].y;
            step();
            check($sformatf("tbl%0d_color", i), colorIndex_out, tbl[i].exp_c);
            check($sformatf("tbl%0d_valid", i), pixel_valid, tbl[i].exp_v);
        end
        idle_inputs();
        check("tbl_no_underrun", underrun, 0);

        // Partial fill, then a swap carrying a write and an underrun clear at once.
        for (int i = 0; i < 300; i++) begin
            fifo_we = 1'b1; fifo_address = 10'(i); data_in = 4'hA;
            step();
        end
        fifo_we = 1'b1; fifo_address = 10'd0; data_in = 4'hA;
        underrun_clr = 1'b1;
        do_swap(0);
        fifo_we = 1'b0;
        underrun_clr = 1'b0;
        check("partial_underrun", underrun, 1);
        check("partial_refill_req", fill_req, 1);
        check("partial_refill_line", fill_line, 1);
        read_px(5, 4'd5, "partial_bank_kept");
        check("partial_valid", pixel_valid, 1);
        clear_underrun();
        check("partial_clr", underrun, 0);

        write_line(1, 639, 1'b1);
        step();
        step();
        do_swap(0);
        check("swap_write_not_counted", underrun, 1);
        clear_underrun();

        write_line(0, 639, 1'b1);
        step();
        step();
        do_swap(0);
        check("swap2_underrun", underrun, 0);
        check("swap2_fill_line", fill_line, 2);
        read_px(5, 4'd10, "swap2_px5");
        read_px(0, 4'd15, "swap2_px0");

        // Reset in the middle of a fill.
        for (int i = 0; i < 100; i++) begin
            fifo_we = 1'b1; fifo_address = 10'(i); data_in = 4'd1;
            pixel_en = 1'b1; DrawX = 10'd5; DrawY = 10'd480;
            step();
        end
        check("pre_reset_color", colorIndex_out, 10);
        Reset_N = 1'b0;
        #1;
        check("midrst_color", colorIndex_out, 0);
        check("midrst_valid", pixel_valid, 0);
        check("midrst_fill_line", fill_line, 0);
        check("midrst_fill_req", fill_req, 0);
        check("midrst_underrun", underrun, 0);
        idle_inputs();
        step();
        step();
        Reset_N = 1'b1;
        wait_fill_req(5, "post_rst_fill_req");
        check("post_rst_fill_line", fill_line, 0);
        check("post_rst_valid", pixel_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
